// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order imem reads for the current PC, pairs each response
// with its address and queues {instr, pc} for decode; redirects flush wrong-path fetches.
module instr_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             redirect,
  output logic             fetch_stall,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] if_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_reg;
  logic [CW-1:0]    outstanding_reg, discard_reg, fifo_count_reg;
  logic [CW-1:0]    discard_next;
  logic [PW-1:0]    addr_wr_reg, addr_rd_reg, ififo_wr_reg, ififo_rd_reg;
  logic [WIDTH-1:0] addr_mem  [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic [CW:0] credit_used;
  logic        credit_ok, req_fire, rsp_fire, rsp_drop, push, pop;

  // Credit covers both in-flight reads and buffered instructions, so neither FIFO can overflow.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
  assign credit_ok      = credit_used < (CW+1)'(DEPTH);
  assign imem_req_valid = rst & (state_reg == RUN) & credit_ok & ~redirect;
  assign imem_req_addr  = pc_i;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign fetch_stall    = ~req_fire;

  assign rsp_fire = imem_rsp_valid & (outstanding_reg != '0);
  assign rsp_drop = rsp_fire & (redirect | (discard_reg != '0));
  assign push     = rsp_fire & ~rsp_drop;

  assign if_valid = rst & (fifo_count_reg != '0);
  assign pop      = if_valid & if_ready;
  assign if_instr = instr_mem[ififo_rd_reg];
  assign if_pc    = pc_mem[ififo_rd_reg];

  // A response landing in the redirect cycle is already excluded from the new discard count.
  always_comb begin
    discard_next = discard_reg;
    if (redirect)
      discard_next = outstanding_reg - CW'(rsp_fire);
    else if (rsp_drop)
      discard_next = discard_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= RUN;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      fifo_count_reg  <= '0;
      addr_wr_reg     <= '0;
      addr_rd_reg     <= '0;
      ififo_wr_reg    <= '0;
      ififo_rd_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]  <= '0;
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      state_reg       <= (discard_next != '0) ? FLUSH : RUN;
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
      discard_reg     <= discard_next;

      if (req_fire) begin
        addr_mem[addr_wr_reg] <= pc_i;
        addr_wr_reg           <= addr_wr_reg + PW'(1);
      end
      // Every response retires its address entry, whether kept or dropped.
      if (rsp_fire)
        addr_rd_reg <= addr_rd_reg + PW'(1);

      if (redirect) begin
        ififo_wr_reg   <= '0;
        ififo_rd_reg   <= '0;
        fifo_count_reg <= '0;
      end else begin
        if (push) begin
          instr_mem[ififo_wr_reg] <= imem_rsp_data;
          pc_mem[ififo_wr_reg]    <= addr_mem[addr_rd_reg];
          ififo_wr_reg            <= ififo_wr_reg + PW'(1);
        end
        if (pop)
          ififo_rd_reg <= ififo_rd_reg + PW'(1);
        fifo_count_reg <= fifo_count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  no_orphan_response: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (outstanding_reg == '0)));

endmodule
